// File: rtl/dataflow_perf_monitor_if.sv
// Handshake taps, control strobes and statistics read port of dataflow_perf_monitor.
// master: host/testbench side; slave: the monitor.
interface dataflow_perf_monitor_if #(
   parameter int NUM_CH = 8,
   parameter int CNT_W  = 32
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              enable;
   logic              clear;
   logic [NUM_CH-1:0] ap_start;
   logic [NUM_CH-1:0] ap_ready;
   logic [NUM_CH-1:0] ap_done;
   logic [NUM_CH-1:0] ap_continue;
   logic              rd_en;
   logic [CH_W-1:0]   rd_ch;
   logic [2:0]        rd_sel;
   logic [CNT_W-1:0]  rd_data;
   logic              rd_valid;
   logic [NUM_CH-1:0] overflow;

   modport master (
      output enable, clear, ap_start, ap_ready, ap_done, ap_continue, rd_en, rd_ch, rd_sel,
      input  rd_data, rd_valid, overflow
   );

   modport slave (
      input  enable, clear, ap_start, ap_ready, ap_done, ap_continue, rd_en, rd_ch, rd_sel,
      output rd_data, rd_valid, overflow
   );
endinterface

// File: rtl/dataflow_perf_monitor.sv
// Per-channel ap_* handshake monitor: txn/busy/done/latency statistics; stall counter under DFMON_STALL_CNT_EN.
// Latency: statistics update on the clock edge that samples the taps; rd_data/rd_valid one cycle after rd_en.
// Backpressure: none; passive observer, a read is accepted every cycle.
module dataflow_perf_monitor #(
   parameter int NUM_CH = 8,
   parameter int CNT_W  = 32,
   parameter int LAT_W  = 24
) (
   input logic                    clock,
   input logic                    reset,
   dataflow_perf_monitor_if.slave bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BUSY      = 2'd1,
      ST_DONE_WAIT = 2'd2
   } state_t;

   logic [CNT_W-1:0]  stats [NUM_CH][8];
   logic [NUM_CH-1:0] ovf_vec;
   logic [CNT_W-1:0]  rd_mux;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_t           state, state_nxt;
      logic [LAT_W-1:0] lat, lat_nxt, lat_now;
      logic [LAT_W-1:0] last_lat, min_lat, max_lat;
      logic [CNT_W-1:0] txn_cnt, busy_cnt, done_cnt, stall_val;
      logic             active, done_ev, lat_sat, stall_ovf, ovf_ev, ovf;
      logic             st, rdy, dn, ct;

      assign st  = bus.ap_start[c];
      assign rdy = bus.ap_ready[c];
      assign dn  = bus.ap_done[c];
      assign ct  = bus.ap_continue[c];

      // lat holds the cycles of the current transaction seen before this one
      always_comb begin
         state_nxt = state;
         lat_nxt   = lat;
         lat_now   = lat;
         active    = 1'b0;
         done_ev   = 1'b0;
         lat_sat   = 1'b0;
         case (state)
            ST_IDLE: begin
               if (st) begin
                  active    = 1'b1;
                  lat_now   = LAT_W'(1);
                  lat_nxt   = LAT_W'(1);
                  state_nxt = ST_BUSY;
               end
            end
            ST_BUSY: begin
               active  = 1'b1;
               lat_sat = &lat;
               lat_now = lat_sat ? lat : lat + LAT_W'(1);
               lat_nxt = lat_now;
            end
            ST_DONE_WAIT: begin
               if (ct) begin
                  state_nxt = st ? ST_BUSY : ST_IDLE;
                  lat_nxt   = LAT_W'(1);
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
         if (active && dn) begin
            done_ev = 1'b1;
            // a start seen in IDLE belongs to the finishing transaction, so only BUSY re-arms
            if (!ct) begin
               state_nxt = ST_DONE_WAIT;
            end else if (st && state == ST_BUSY) begin
               state_nxt = ST_BUSY;
               lat_nxt   = LAT_W'(1);
            end else begin
               state_nxt = ST_IDLE;
            end
         end
      end

      assign ovf_ev = bus.enable & ((st & rdy & (&txn_cnt)) | (active & (&busy_cnt)) |
                                    (done_ev & (&done_cnt)) | lat_sat | stall_ovf);

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            state    <= ST_IDLE;
            lat      <= '0;
            txn_cnt  <= '0;
            busy_cnt <= '0;
            done_cnt <= '0;
            last_lat <= '0;
            min_lat  <= '1;
            max_lat  <= '0;
            ovf      <= 1'b0;
         end else if (bus.clear) begin
            state    <= ST_IDLE;
            lat      <= '0;
            txn_cnt  <= '0;
            busy_cnt <= '0;
            done_cnt <= '0;
            last_lat <= '0;
            min_lat  <= '1;
            max_lat  <= '0;
            ovf      <= 1'b0;
         end else begin
            state <= state_nxt;
            lat   <= lat_nxt;
            if (bus.enable) begin
               if (st & rdy) txn_cnt <= sat_inc(txn_cnt);
               if (active)   busy_cnt <= sat_inc(busy_cnt);
               if (done_ev) begin
                  done_cnt <= sat_inc(done_cnt);
                  last_lat <= lat_now;
                  if (lat_now < min_lat) min_lat <= lat_now;
                  if (lat_now > max_lat) max_lat <= lat_now;
               end
               if (ovf_ev) ovf <= 1'b1;
            end
         end
      end

`ifdef DFMON_STALL_CNT_EN
      logic [CNT_W-1:0] stall_cnt;
      logic             stall_ev;

      assign stall_ev  = (state == ST_DONE_WAIT) | (st & ~rdy);
      assign stall_ovf = bus.enable & stall_ev & (&stall_cnt);
      assign stall_val = stall_cnt;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset)                       stall_cnt <= '0;
         else if (bus.clear)               stall_cnt <= '0;
         else if (bus.enable && stall_ev)  stall_cnt <= sat_inc(stall_cnt);
      end
`else
      assign stall_ovf = 1'b0;
      assign stall_val = '0;
`endif

      assign stats[c][0] = txn_cnt;
      assign stats[c][1] = busy_cnt;
      assign stats[c][2] = done_cnt;
      assign stats[c][3] = CNT_W'(last_lat);
      assign stats[c][4] = CNT_W'(min_lat);
      assign stats[c][5] = CNT_W'(max_lat);
      assign stats[c][6] = stall_val;
      assign stats[c][7] = CNT_W'({ovf, state});
      assign ovf_vec[c]  = ovf;
   end

   // out-of-range channels fall through to zero
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.rd_ch == CH_W'(i)) rd_mux = stats[i][bus.rd_sel];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus.rd_data  <= '0;
         bus.rd_valid <= 1'b0;
      end else begin
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en) bus.rd_data <= rd_mux;
      end
   end

   assign bus.overflow = ovf_vec;
endmodule

// File: tb/tb_dataflow_perf_monitor.sv
// Self-checking bench for dataflow_perf_monitor: directed scenarios plus randomized traffic
// against a timestamp-based reference model.
module tb_dataflow_perf_monitor;
   localparam int NUM_CH  = 5;
   localparam int CNT_W   = 8;
   localparam int LAT_W   = 6;
   localparam int CNT_MAX = 255;
   localparam int LAT_MAX = 63;
`ifdef DFMON_STALL_CNT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;

   dataflow_perf_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   dataflow_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .LAT_W(LAT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model: state 0 idle, 1 in flight, 2 waiting for continue; latency from timestamps
   int m_state [NUM_CH];
   int m_tstart[NUM_CH];
   int m_txn   [NUM_CH];
   int m_busy  [NUM_CH];
   int m_done  [NUM_CH];
   int m_last  [NUM_CH];
   int m_min   [NUM_CH];
   int m_max   [NUM_CH];
   int m_stall [NUM_CH];
   bit m_ovf   [NUM_CH];

   function automatic void model_clear(int ch);
      m_state[ch] = 0; m_tstart[ch] = 0; m_txn[ch] = 0; m_busy[ch] = 0; m_done[ch] = 0;
      m_last[ch] = 0; m_min[ch] = LAT_MAX; m_max[ch] = 0; m_stall[ch] = 0; m_ovf[ch] = 1'b0;
   endfunction

   function automatic void model_reset_all();
      for (int ch = 0; ch < NUM_CH; ch++) model_clear(ch);
   endfunction

   function automatic int bump(int v, int ch);
      if (v >= CNT_MAX) begin
         m_ovf[ch] = 1'b1;
         return CNT_MAX;
      end
      return v + 1;
   endfunction

   function automatic void model_step();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         bit s, r, d, k, engaged;
         int st, lat_raw, lat;
         s = bus.ap_start[ch]; r = bus.ap_ready[ch]; d = bus.ap_done[ch]; k = bus.ap_continue[ch];
         if (bus.clear) begin
            model_clear(ch);
            continue;
         end
         st = m_state[ch];
         engaged = (st == 1) || (st == 0 && s);
         if (st == 0 && s) m_tstart[ch] = cyc;
         lat_raw = cyc - m_tstart[ch] + 1;
         lat = (lat_raw > LAT_MAX) ? LAT_MAX : lat_raw;
         if (bus.enable) begin
            if (s && r) m_txn[ch] = bump(m_txn[ch], ch);
            if (engaged) m_busy[ch] = bump(m_busy[ch], ch);
            if (st == 1 && lat_raw > LAT_MAX) m_ovf[ch] = 1'b1;
            if (STALL_EN && (st == 2 || (s && !r))) m_stall[ch] = bump(m_stall[ch], ch);
            if (engaged && d) begin
               m_done[ch] = bump(m_done[ch], ch);
               m_last[ch] = lat;
               if (lat < m_min[ch]) m_min[ch] = lat;
               if (lat > m_max[ch]) m_max[ch] = lat;
            end
         end
         if (engaged && d) begin
            if (!k) m_state[ch] = 2;
            else if (st == 1 && s) begin m_state[ch] = 1; m_tstart[ch] = cyc; end
            else m_state[ch] = 0;
         end else if (st == 0 && s) begin
            m_state[ch] = 1;
         end else if (st == 2 && k) begin
            m_state[ch] = s ? 1 : 0;
            if (s) m_tstart[ch] = cyc;
         end
      end
      cyc++;
   endfunction

   function automatic int model_read(int ch, int sel);
      if (ch >= NUM_CH) return 0;
      case (sel)
         0: return m_txn[ch];
         1: return m_busy[ch];
         2: return m_done[ch];
         3: return m_last[ch];
         4: return m_min[ch];
         5: return m_max[ch];
         6: return m_stall[ch];
         default: return (int'(m_ovf[ch]) << 2) | m_state[ch];
      endcase
   endfunction

   function automatic logic [NUM_CH-1:0] model_ovf_vec();
      logic [NUM_CH-1:0] v;
      for (int ch = 0; ch < NUM_CH; ch++) v[ch] = m_ovf[ch];
      return v;
   endfunction

   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      bus.enable = 1'b1; bus.clear = 1'b0;
      bus.ap_start = '0; bus.ap_ready = '0; bus.ap_done = '0; bus.ap_continue = '1;
      bus.rd_en = 1'b0; bus.rd_ch = '0; bus.rd_sel = '0;
   endtask

   task automatic set_ch(int ch, bit s, bit d, bit k);
      bus.ap_start[ch] = s; bus.ap_ready[ch] = s; bus.ap_done[ch] = d; bus.ap_continue[ch] = k;
   endtask

   task automatic read_stat(input int ch, input int sel, output logic [CNT_W-1:0] got,
                            output logic vld, output int expv);
      bus.rd_en = 1'b1; bus.rd_ch = ch[2:0]; bus.rd_sel = sel[2:0];
      expv = model_read(ch, sel);
      tick();
      got = bus.rd_data; vld = bus.rd_valid;
      bus.rd_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [CNT_W-1:0] got; logic v; int e, want;
      idle_inputs();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      n_tests++;
      if (bus.overflow !== '0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: ovf=%b vld=%b data=%0d, required all 0", bus.overflow, bus.rd_valid, bus.rd_data);
      end
      reset = 1'b1;
      model_reset_all();
      @(negedge clock);
      for (int ch = 0; ch < 8; ch++) begin
         for (int sel = 0; sel < 8; sel++) begin
            read_stat(ch, sel, got, v, e);
            want = (sel == 4 && ch < NUM_CH) ? LAT_MAX : 0;
            n_tests++;
            if (v !== 1'b1 || got !== CNT_W'(want)) begin
               n_fail++;
               $display("FAIL reset_read ch%0d sel%0d: got %0d vld %b, required %0d vld 1", ch, sel, got, v, want);
            end
         end
      end
   endtask

   task automatic test_single();
      logic [CNT_W-1:0] got; logic v; int e;
      int want[8] = '{1, 6, 1, 6, 6, 6, 0, 0};
      set_ch(0, 1, 0, 1); tick();
      set_ch(0, 0, 0, 1); repeat (4) tick();
      set_ch(0, 0, 1, 1); tick();
      set_ch(0, 0, 0, 1);
      for (int sel = 0; sel < 8; sel++) begin
         if (sel == 6) continue;
         read_stat(0, sel, got, v, e);
         n_tests++;
         if (v !== 1'b1 || got !== CNT_W'(want[sel])) begin
            n_fail++;
            $display("FAIL single sel%0d: got %0d vld %b, required %0d", sel, got, v, want[sel]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [CNT_W-1:0] got; logic v; int e, want_st;
      int want[6] = '{3, 11, 3, 7, 2, 7};
      for (int i = 0; i < 12; i++) begin
         set_ch(3, (i == 0 || i == 3 || i == 4), (i == 3 || i == 4 || i == 10), 1);
         read_stat(3, 7, got, v, e);
         want_st = (i >= 1 && i <= 10) ? 1 : 0;
         n_tests++;
         if (got !== CNT_W'(want_st)) begin
            n_fail++;
            $display("FAIL b2b_state cycle%0d: got %0d, required %0d", i, got, want_st);
         end
      end
      set_ch(3, 0, 0, 1);
      for (int sel = 0; sel < 6; sel++) begin
         read_stat(3, sel, got, v, e);
         n_tests++;
         if (got !== CNT_W'(want[sel])) begin
            n_fail++;
            $display("FAIL b2b_stat sel%0d: got %0d, required %0d", sel, got, want[sel]);
         end
      end
   endtask

   task automatic test_stall();
      logic [CNT_W-1:0] got; logic v; int e, want_st, want_stall;
      for (int i = 0; i < 8; i++) begin
         set_ch(1, (i == 0), (i == 2), !(i >= 2 && i <= 4));
         read_stat(1, 7, got, v, e);
         want_st = (i >= 3 && i <= 5) ? 2 : ((i == 1 || i == 2) ? 1 : 0);
         n_tests++;
         if (got !== CNT_W'(want_st)) begin
            n_fail++;
            $display("FAIL stall_state cycle%0d: got %0d, required %0d", i, got, want_st);
         end
      end
      set_ch(1, 0, 0, 1);
      want_stall = STALL_EN ? 3 : 0;
      read_stat(1, 6, got, v, e);
      n_tests++;
      if (got !== CNT_W'(want_stall)) begin
         n_fail++;
         $display("FAIL stall_cnt: got %0d, required %0d", got, want_stall);
      end
      read_stat(1, 3, got, v, e);
      n_tests++;
      if (got !== CNT_W'(3)) begin
         n_fail++;
         $display("FAIL stall_last_lat: got %0d, required 3", got);
      end
   endtask

   task automatic test_saturation_clear();
      logic [CNT_W-1:0] got; logic v; int e, want;
      set_ch(2, 1, 1, 1);
      repeat (300) tick();
      set_ch(2, 0, 0, 1);
      for (int sel = 0; sel < 3; sel++) begin
         read_stat(2, sel, got, v, e);
         n_tests++;
         if (got !== CNT_W'(CNT_MAX)) begin
            n_fail++;
            $display("FAIL sat_count sel%0d: got %0d, required %0d", sel, got, CNT_MAX);
         end
      end
      n_tests++;
      if (bus.overflow[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_overflow: got %b, required 1", bus.overflow[2]);
      end
      bus.clear = 1'b1; tick(); bus.clear = 1'b0;
      n_tests++;
      if (bus.overflow !== '0) begin
         n_fail++;
         $display("FAIL clear_overflow: got %b, required 0", bus.overflow);
      end
      for (int sel = 0; sel < 8; sel++) begin
         read_stat(2, sel, got, v, e);
         want = (sel == 4) ? LAT_MAX : 0;
         n_tests++;
         if (got !== CNT_W'(want)) begin
            n_fail++;
            $display("FAIL clear_read sel%0d: got %0d, required %0d", sel, got, want);
         end
      end
      set_ch(2, 1, 0, 1); tick();
      set_ch(2, 0, 1, 1); bus.clear = 1'b1; tick();
      set_ch(2, 0, 0, 1); bus.clear = 1'b0;
      read_stat(2, 2, got, v, e);
      n_tests++;
      if (got !== '0) begin
         n_fail++;
         $display("FAIL clear_with_done done_cnt: got %0d, required 0", got);
      end
      read_stat(2, 7, got, v, e);
      n_tests++;
      if (got !== '0) begin
         n_fail++;
         $display("FAIL clear_with_done status: got %0d, required 0", got);
      end
      // latency counter saturation on ch4
      set_ch(4, 1, 0, 1); tick();
      set_ch(4, 0, 0, 1); repeat (69) tick();
      set_ch(4, 0, 1, 1); tick();
      set_ch(4, 0, 0, 1);
      read_stat(4, 3, got, v, e);
      n_tests++;
      if (got !== CNT_W'(LAT_MAX) || bus.overflow[4] !== 1'b1) begin
         n_fail++;
         $display("FAIL lat_saturate: last %0d ovf %b, required %0d ovf 1", got, bus.overflow[4], LAT_MAX);
      end
      bus.clear = 1'b1; tick(); bus.clear = 1'b0;
   endtask

   task automatic test_enable_reset();
      logic [CNT_W-1:0] got; logic v; int e;
      int want[4] = '{1, 2, 1, 5};
      set_ch(0, 1, 0, 1); tick();
      bus.enable = 1'b0;
      set_ch(0, 0, 0, 1); tick();
      set_ch(1, 1, 0, 1); tick();
      set_ch(1, 0, 0, 1); tick();
      bus.enable = 1'b1;
      set_ch(0, 0, 1, 1); tick();
      set_ch(0, 0, 0, 1);
      for (int sel = 0; sel < 4; sel++) begin
         read_stat(0, sel, got, v, e);
         n_tests++;
         if (got !== CNT_W'(want[sel])) begin
            n_fail++;
            $display("FAIL enable_ch0 sel%0d: got %0d, required %0d", sel, got, want[sel]);
         end
      end
      read_stat(1, 0, got, v, e);
      n_tests++;
      if (got !== '0) begin
         n_fail++;
         $display("FAIL enable_ch1_txn: got %0d, required 0", got);
      end
      read_stat(1, 7, got, v, e);
      n_tests++;
      if (got !== CNT_W'(1)) begin
         n_fail++;
         $display("FAIL enable_ch1_state: got %0d, required 1", got);
      end
      set_ch(0, 1, 0, 1); tick();
      set_ch(0, 0, 0, 1); repeat (70) tick();
      read_stat(0, 1, got, v, e);
      n_tests++;
      if (got !== CNT_W'(e) || bus.overflow[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_before_reset: got %0d ovf %b, required %0d ovf 1", got, bus.overflow[0], e);
      end
      #2 reset = 1'b0;
      #1;
      n_tests++;
      if (bus.overflow !== '0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
         n_fail++;
         $display("FAIL async_reset: ovf=%b vld=%b data=%0d, required all 0", bus.overflow, bus.rd_valid, bus.rd_data);
      end
      @(negedge clock);
      reset = 1'b1;
      model_reset_all();
      read_stat(0, 7, got, v, e);
      n_tests++;
      if (got !== '0) begin
         n_fail++;
         $display("FAIL post_reset_state: got %0d, required 0", got);
      end
      read_stat(0, 4, got, v, e);
      n_tests++;
      if (got !== CNT_W'(LAT_MAX)) begin
         n_fail++;
         $display("FAIL post_reset_min: got %0d, required %0d", got, LAT_MAX);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         logic [CNT_W-1:0] got; logic v; int e, rc, rs; bit re;
         bus.enable = ($urandom_range(0, 9) != 0);
         bus.clear  = ($urandom_range(0, 299) == 0);
         for (int ch = 0; ch < NUM_CH; ch++) begin
            bus.ap_start[ch]    = ($urandom_range(0, 2) == 0);
            bus.ap_ready[ch]    = ($urandom_range(0, 9) < 7);
            bus.ap_done[ch]     = ($urandom_range(0, 3) == 0);
            bus.ap_continue[ch] = ($urandom_range(0, 9) < 7);
         end
         re = $urandom_range(0, 1);
         rc = $urandom_range(0, 7);
         rs = $urandom_range(0, 7);
         if (re) begin
            read_stat(rc, rs, got, v, e);
         end else begin
            e = 0;
            tick();
            got = bus.rd_data; v = bus.rd_valid;
         end
         n_tests++;
         if (re ? (v !== 1'b1 || got !== CNT_W'(e)) : (v !== 1'b0)) begin
            n_fail++;
            $display("FAIL random_read i%0d ch%0d sel%0d rd%0b: got %0d vld %b, required %0d", i, rc, rs, re, got, v, e);
         end
         n_tests++;
         if (bus.overflow !== model_ovf_vec()) begin
            n_fail++;
            $display("FAIL random_overflow i%0d: got %b, required %b", i, bus.overflow, model_ovf_vec());
         end
      end
      idle_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset_all();
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_saturation_clear();
      test_enable_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
